// File: rtl/apb_pad_ctrl_pkg.sv
// apb_pad_ctrl_pkg: register offsets, CTRL bit positions, APB FSM states and
// the error read pattern shared by the pad-control block and its bus interface.
package apb_pad_ctrl_pkg;

   // Register byte offsets (only PADDR[11:0] is decoded)
   localparam logic [11:0] OFS_INFO     = 12'h000;
   localparam logic [11:0] OFS_CTRL     = 12'h004;
   localparam logic [11:0] OFS_INDEX    = 12'h008;
   localparam logic [11:0] OFS_DATA     = 12'h00C;
   localparam logic [11:0] OFS_COMMIT   = 12'h010;
   localparam logic [11:0] OFS_STATUS   = 12'h014;
   localparam logic [11:0] OFS_PAD_BASE = 12'h400;

   // CTRL bit positions
   localparam int CTRL_SHADOW_BIT  = 0;
   localparam int CTRL_AUTOINC_BIT = 1;
   localparam int CTRL_LOCK_BIT    = 31;

   // Read data returned on an errored read
   localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

   // APB handshake states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_pad_ctrl_regif.sv
// apb_pad_ctrl_regif: APB handshake FSM. Turns a PSEL&PENABLE phase into a
// single-cycle read or write strobe and registers the response
// (PRDATA/PSLVERR/PREADY) so PREADY rises two cycles after PENABLE is seen.
module apb_pad_ctrl_regif
   import apb_pad_ctrl_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic                      wr_stb,
   output logic                      rd_stb,
   output logic [11:0]               addr,
   output logic [31:0]               wdata,
   input  logic [31:0]               rdata_i,
   input  logic                      err_i
);

   apb_state_e  state_q, state_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pslverr_q, pslverr_d;
   logic        pready_q, pready_d;

   // The master holds address/data stable until PREADY, so the strobes can
   // use the live bus during ACCESS.
   assign wr_stb = (state_q == ACCESS) &&  PWRITE;
   assign rd_stb = (state_q == ACCESS) && !PWRITE;
   assign addr   = PADDR[11:0];
   assign wdata  = PWDATA;

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

   // Next-state and response capture for the handshake
   always_comb begin
      state_d   = state_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      pready_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (PSEL && PENABLE) state_d = ACCESS;
         end
         ACCESS: begin
            prdata_d  = rdata_i;
            pslverr_d = err_i;
            pready_d  = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and response registers; reset aborts any transfer in flight
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         prdata_q  <= 32'h0;
         pslverr_q <= 1'b0;
         pready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         pready_q  <= pready_d;
      end
   end

endmodule

// File: rtl/apb_pad_ctrl_gen2.sv
// apb_pad_ctrl_gen2: APB pad-configuration block with shadow/active banks,
// indexed data window with auto-increment, direct per-pad window and commit.
// Optional sticky write lock enabled by defining APB_PAD_CTRL_LOCK_EN.
module apb_pad_ctrl_gen2
   import apb_pad_ctrl_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int N_IO           = 64,
   parameter int NBIT_PADCFG    = 6,
   parameter int NBIT_PADMUX    = 2
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
   input  logic [31:0]                   PWDATA,
   input  logic                          PWRITE,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   output logic [31:0]                   PRDATA,
   output logic                          PREADY,
   output logic                          PSLVERR,
   output logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_o,
   output logic [N_IO*NBIT_PADMUX-1:0]   pad_mux_o,
   output logic                          update_o
);

   localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;

   logic        wr_stb, rd_stb, err;
   logic [11:0] addr;
   logic [31:0] wdata, rdata;

   logic [NBIT_PADCFG-1:0] cfg_sh_q  [N_IO];
   logic [NBIT_PADCFG-1:0] cfg_sh_d  [N_IO];
   logic [NBIT_PADCFG-1:0] cfg_act_q [N_IO];
   logic [NBIT_PADCFG-1:0] cfg_act_d [N_IO];
   logic [NBIT_PADMUX-1:0] mux_sh_q  [N_IO];
   logic [NBIT_PADMUX-1:0] mux_sh_d  [N_IO];
   logic [NBIT_PADMUX-1:0] mux_act_q [N_IO];
   logic [NBIT_PADMUX-1:0] mux_act_d [N_IO];

   logic [1:0]       ctrl_q, ctrl_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             pending_q, pending_d;
   logic             update_q, update_d;
   logic             locked;

   logic             is_direct, pad_wr, do_commit, step_idx;
   logic [7:0]       direct_idx;
   logic [IDX_W-1:0] pad_sel;
   logic [31:0]      pad_rd;

   apb_pad_ctrl_regif #(
      .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
   ) u_regif (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PWRITE  (PWRITE),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .wr_stb  (wr_stb),
      .rd_stb  (rd_stb),
      .addr    (addr),
      .wdata   (wdata),
      .rdata_i (rdata),
      .err_i   (err)
   );

`ifdef APB_PAD_CTRL_LOCK_EN
   logic lock_q, lock_d;
   assign locked = lock_q;

   // Sticky lock: set by an accepted CTRL write with bit31, cleared by reset only
   always_comb begin
      lock_d = lock_q | (wr_stb && (addr == OFS_CTRL) && wdata[CTRL_LOCK_BIT]);
   end

   // Lock register
   always_ff @(posedge HCLK) begin
      if (!HRESETn) lock_q <= 1'b0;
      else          lock_q <= lock_d;
   end
`else
   assign locked = 1'b0;
`endif

   // Window decode; direct pad addresses use the word index of the offset
   assign is_direct  = (addr[11:10] == 2'b01) && (addr[1:0] == 2'b00);
   assign direct_idx = addr[9:2];
   assign pad_sel    = is_direct ? direct_idx[IDX_W-1:0] : index_q;

   // Reads always show the shadow bank, unused bits zero
   always_comb begin
      pad_rd = 32'h0;
      pad_rd[8 +: NBIT_PADCFG] = cfg_sh_q[pad_sel];
      pad_rd[0 +: NBIT_PADMUX] = mux_sh_q[pad_sel];
   end

   // Register decode, bank updates, commit and index stepping
   always_comb begin
      cfg_sh_d  = cfg_sh_q;
      cfg_act_d = cfg_act_q;
      mux_sh_d  = mux_sh_q;
      mux_act_d = mux_act_q;
      ctrl_d    = ctrl_q;
      index_d   = index_q;
      pending_d = pending_q;
      update_d  = 1'b0;
      rdata     = 32'h0;
      err       = 1'b0;
      pad_wr    = 1'b0;
      do_commit = 1'b0;
      step_idx  = 1'b0;

      if (wr_stb || rd_stb) begin
         if (is_direct) begin
            if ({24'h0, direct_idx} >= 32'(N_IO)) err = 1'b1;
            else if (wr_stb && locked)             err = 1'b1;
            else if (wr_stb)                       pad_wr = 1'b1;
            else                                   rdata = pad_rd;
         end else begin
            case (addr)
               OFS_INFO: begin
                  if (rd_stb) rdata = {16'(N_IO), 8'(NBIT_PADMUX), 8'(NBIT_PADCFG)};
               end
               OFS_CTRL: begin
                  if (rd_stb) begin
                     rdata = {locked, 29'h0, ctrl_q};
                  end else if (locked) begin
                     err = 1'b1;
                  end else begin
                     ctrl_d = {wdata[CTRL_AUTOINC_BIT], wdata[CTRL_SHADOW_BIT]};
                     // Dropping out of shadow mode must not strand staged values
                     if (ctrl_q[CTRL_SHADOW_BIT] && !wdata[CTRL_SHADOW_BIT] && pending_q)
                        do_commit = 1'b1;
                  end
               end
               OFS_INDEX: begin
                  if (rd_stb)                     rdata = 32'(index_q);
                  else if (locked)                err = 1'b1;
                  else if (wdata >= 32'(N_IO))    err = 1'b1;
                  else                            index_d = wdata[IDX_W-1:0];
               end
               OFS_DATA: begin
                  if (rd_stb) begin
                     rdata    = pad_rd;
                     step_idx = 1'b1;
                  end else if (locked) begin
                     err = 1'b1;
                  end else begin
                     pad_wr   = 1'b1;
                     step_idx = 1'b1;
                  end
               end
               OFS_COMMIT: begin
                  if (wr_stb) begin
                     if (locked) err = 1'b1;
                     else if (wdata[0] && ctrl_q[CTRL_SHADOW_BIT] && pending_q) do_commit = 1'b1;
                  end
               end
               OFS_STATUS: begin
                  if (rd_stb) rdata = {31'h0, pending_q};
               end
               default: err = 1'b1;
            endcase
         end
         if (err && rd_stb) rdata = ERR_RDATA;
      end

      if (pad_wr) begin
         cfg_sh_d[pad_sel] = wdata[8 +: NBIT_PADCFG];
         mux_sh_d[pad_sel] = wdata[0 +: NBIT_PADMUX];
         if (ctrl_q[CTRL_SHADOW_BIT]) begin
            pending_d = 1'b1;
         end else begin
            cfg_act_d[pad_sel] = wdata[8 +: NBIT_PADCFG];
            mux_act_d[pad_sel] = wdata[0 +: NBIT_PADMUX];
            update_d           = 1'b1;
         end
      end

      if (do_commit) begin
         cfg_act_d = cfg_sh_q;
         mux_act_d = mux_sh_q;
         pending_d = 1'b0;
         update_d  = 1'b1;
      end

      if (step_idx && ctrl_q[CTRL_AUTOINC_BIT])
         index_d = (index_q == IDX_W'(N_IO - 1)) ? '0 : index_q + 1'b1;
   end

   // Bank and control registers
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         for (int i = 0; i < N_IO; i++) begin
            cfg_sh_q[i]  <= '1;
            cfg_act_q[i] <= '1;
            mux_sh_q[i]  <= '0;
            mux_act_q[i] <= '0;
         end
         ctrl_q    <= 2'b00;
         index_q   <= '0;
         pending_q <= 1'b0;
         update_q  <= 1'b0;
      end else begin
         cfg_sh_q  <= cfg_sh_d;
         cfg_act_q <= cfg_act_d;
         mux_sh_q  <= mux_sh_d;
         mux_act_q <= mux_act_d;
         ctrl_q    <= ctrl_d;
         index_q   <= index_d;
         pending_q <= pending_d;
         update_q  <= update_d;
      end
   end

   assign update_o = update_q;

   // Flatten the active bank onto the pad-frame buses
   for (genvar gi = 0; gi < N_IO; gi++) begin : g_pad_out
      assign pad_cfg_o[gi*NBIT_PADCFG +: NBIT_PADCFG] = cfg_act_q[gi];
      assign pad_mux_o[gi*NBIT_PADMUX +: NBIT_PADMUX] = mux_act_q[gi];
   end

endmodule

// File: tb/tb_apb_pad_ctrl_gen2.sv
// tb_apb_pad_ctrl_gen2: directed tests of the APB pad controller with
// hand-computed expectations (N_IO=64, NBIT_PADCFG=6, NBIT_PADMUX=2).
module tb_apb_pad_ctrl_gen2;

   logic         HCLK = 1'b0;
   logic         HRESETn;
   logic [11:0]  PADDR;
   logic [31:0]  PWDATA;
   logic         PWRITE, PSEL, PENABLE;
   logic [31:0]  PRDATA;
   logic         PREADY, PSLVERR;
   logic [383:0] pad_cfg_o;
   logic [127:0] pad_mux_o;
   logic         update_o;

   int n_cmp = 0;
   int n_mis = 0;
   int upd_cnt = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          u0;

   apb_pad_ctrl_gen2 dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .pad_cfg_o (pad_cfg_o),
      .pad_mux_o (pad_mux_o),
      .update_o  (update_o)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) if (update_o === 1'b1) upd_cnt++;

   task automatic do_reset();
      HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 12'h0; PWDATA = 32'h0;
      repeat (3) @(posedge HCLK);
      #1;
   endtask

   task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rdo, output logic ero, output int lato);
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      lato = 0;
      while (PREADY !== 1'b1 && lato < 20) begin
         @(posedge HCLK); #1;
         lato++;
      end
      rdo = PRDATA; ero = PSLVERR;
      PSEL = 1'b0; PENABLE = 1'b0;
      n_cmp++;
      if (lato >= 20) begin
         n_mis++;
         $display("FAIL apb_timeout addr=%h: no PREADY, required within 20 cycles", a);
      end
      $display("apb %s addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
               wr ? "WR" : "RD", a, wd, rdo, ero, lato);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0 || update_o !== 1'b0) begin
         n_mis++; $display("FAIL reset_outs: got ready=%b err=%b rdata=%h upd=%b, required 0", PREADY, PSLVERR, PRDATA, update_o); end
      n_cmp++; if (pad_cfg_o !== {384{1'b1}}) begin
         n_mis++; $display("FAIL reset_cfg: got %h, required all ones", pad_cfg_o); end
      n_cmp++; if (pad_mux_o !== 128'h0) begin
         n_mis++; $display("FAIL reset_mux: got %h, required 0", pad_mux_o); end
      HRESETn = 1'b1;
      apb(0, 12'h000, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h00400206 || er !== 1'b0) begin
         n_mis++; $display("FAIL info_read: got %h err=%b, required 00400206 err=0", rd, er); end
      n_cmp++; if (lat !== 2) begin
         n_mis++; $display("FAIL ready_latency: got %0d, required 2", lat); end
      @(posedge HCLK); #1;
      n_cmp++; if (PREADY !== 1'b0) begin
         n_mis++; $display("FAIL ready_pulse_width: got %b one cycle later, required 0", PREADY); end
   endtask

   task automatic test_direct();
      u0 = upd_cnt;
      apb(1, 12'h414, 32'h00002A03, rd, er, lat);
      n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin
         n_mis++; $display("FAIL direct_wr_resp: got rdata=%h err=%b, required 0/0", rd, er); end
      n_cmp++; if (pad_cfg_o[5*6 +: 6] !== 6'h2A || pad_mux_o[5*2 +: 2] !== 2'h3) begin
         n_mis++; $display("FAIL direct_wr_pad5: got cfg=%h mux=%h, required 2a/3", pad_cfg_o[5*6 +: 6], pad_mux_o[5*2 +: 2]); end
      n_cmp++; if (update_o !== 1'b1) begin
         n_mis++; $display("FAIL direct_update_hi: got %b, required 1", update_o); end
      @(posedge HCLK); #1;
      n_cmp++; if (update_o !== 1'b0 || upd_cnt - u0 !== 1) begin
         n_mis++; $display("FAIL direct_update_pulse: got upd=%b pulses=%0d, required 0/1", update_o, upd_cnt - u0); end
      apb(0, 12'h414, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h00002A03 || er !== 1'b0) begin
         n_mis++; $display("FAIL direct_readback: got %h, required 00002a03", rd); end
   endtask

   task automatic test_shadow_autoinc();
      u0 = upd_cnt;
      apb(1, 12'h004, 32'h3, rd, er, lat);
      apb(1, 12'h008, 32'd62, rd, er, lat);
      apb(1, 12'h00C, 32'h101, rd, er, lat);
      apb(1, 12'h00C, 32'h202, rd, er, lat);
      apb(1, 12'h00C, 32'h303, rd, er, lat);
      apb(0, 12'h008, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'd1) begin
         n_mis++; $display("FAIL autoinc_wrap_index: got %0d, required 1", rd); end
      apb(0, 12'h014, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h1) begin
         n_mis++; $display("FAIL pending_set: got %h, required 1", rd); end
      n_cmp++; if (pad_cfg_o[62*6 +: 6] !== 6'h3F || pad_mux_o[62*2 +: 2] !== 2'h0 ||
                   pad_cfg_o[0 +: 6] !== 6'h3F || pad_mux_o[0 +: 2] !== 2'h0 || upd_cnt - u0 !== 0) begin
         n_mis++; $display("FAIL staged_outputs_held: got p62=%h/%h p0=%h/%h pulses=%0d, required 3f/0 3f/0 0",
                           pad_cfg_o[62*6 +: 6], pad_mux_o[62*2 +: 2], pad_cfg_o[0 +: 6], pad_mux_o[0 +: 2], upd_cnt - u0); end
      apb(1, 12'h010, 32'h1, rd, er, lat);
      @(posedge HCLK); #1;
      n_cmp++; if (pad_cfg_o[62*6 +: 6] !== 6'h01 || pad_mux_o[62*2 +: 2] !== 2'h1 ||
                   pad_cfg_o[63*6 +: 6] !== 6'h02 || pad_mux_o[63*2 +: 2] !== 2'h2 ||
                   pad_cfg_o[0 +: 6] !== 6'h03 || pad_mux_o[0 +: 2] !== 2'h3) begin
         n_mis++; $display("FAIL commit_applied: got p62=%h/%h p63=%h/%h p0=%h/%h, required 01/1 02/2 03/3",
                           pad_cfg_o[62*6 +: 6], pad_mux_o[62*2 +: 2], pad_cfg_o[63*6 +: 6], pad_mux_o[63*2 +: 2],
                           pad_cfg_o[0 +: 6], pad_mux_o[0 +: 2]); end
      n_cmp++; if (upd_cnt - u0 !== 1) begin
         n_mis++; $display("FAIL commit_single_update: got %0d pulses, required 1", upd_cnt - u0); end
      apb(0, 12'h014, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h0) begin
         n_mis++; $display("FAIL pending_clear: got %h, required 0", rd); end
      apb(0, 12'h00C, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h00003F00) begin
         n_mis++; $display("FAIL data_read_pad1: got %h, required 00003f00", rd); end
      apb(0, 12'h008, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'd2) begin
         n_mis++; $display("FAIL data_read_autoinc: got %0d, required 2", rd); end
   endtask

   task automatic test_errors();
      apb(1, 12'h008, 32'd64, rd, er, lat);
      n_cmp++; if (er !== 1'b1) begin
         n_mis++; $display("FAIL index_oob_err: got %b, required 1", er); end
      apb(0, 12'h008, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'd2 || er !== 1'b0) begin
         n_mis++; $display("FAIL index_unchanged: got %0d err=%b, required 2 err=0", rd, er); end
      apb(0, 12'h500, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b1) begin
         n_mis++; $display("FAIL direct_oob_read: got %h err=%b, required deadbeef err=1", rd, er); end
      apb(0, 12'h018, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b1) begin
         n_mis++; $display("FAIL unmapped_read: got %h err=%b, required deadbeef err=1", rd, er); end
      apb(1, 12'h018, 32'h5, rd, er, lat);
      n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin
         n_mis++; $display("FAIL unmapped_write: got %h err=%b, required 0 err=1", rd, er); end
      apb(0, 12'h4FC, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h00000202 || er !== 1'b0) begin
         n_mis++; $display("FAIL direct_last_pad: got %h err=%b, required 00000202 err=0", rd, er); end
   endtask

   task automatic test_implicit_commit();
      apb(1, 12'h004, 32'h1, rd, er, lat);
      apb(1, 12'h40C, 32'h00001502, rd, er, lat);
      n_cmp++; if (pad_cfg_o[3*6 +: 6] !== 6'h3F || pad_mux_o[3*2 +: 2] !== 2'h0) begin
         n_mis++; $display("FAIL implicit_staged: got %h/%h, required 3f/0", pad_cfg_o[3*6 +: 6], pad_mux_o[3*2 +: 2]); end
      u0 = upd_cnt;
      apb(1, 12'h004, 32'h0, rd, er, lat);
      @(posedge HCLK); #1;
      n_cmp++; if (pad_cfg_o[3*6 +: 6] !== 6'h15 || pad_mux_o[3*2 +: 2] !== 2'h2 || upd_cnt - u0 !== 1) begin
         n_mis++; $display("FAIL implicit_commit: got %h/%h pulses=%0d, required 15/2 1",
                           pad_cfg_o[3*6 +: 6], pad_mux_o[3*2 +: 2], upd_cnt - u0); end
      apb(0, 12'h014, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h0) begin
         n_mis++; $display("FAIL implicit_pending_clear: got %h, required 0", rd); end
   endtask

   task automatic test_back_to_back();
      u0 = upd_cnt;
      apb(1, 12'h428, 32'h00000701, rd, er, lat);
      apb(1, 12'h42C, 32'h00000902, rd, er, lat);
      @(posedge HCLK); #1;
      n_cmp++; if (pad_cfg_o[10*6 +: 6] !== 6'h07 || pad_mux_o[10*2 +: 2] !== 2'h1 ||
                   pad_cfg_o[11*6 +: 6] !== 6'h09 || pad_mux_o[11*2 +: 2] !== 2'h2 || upd_cnt - u0 !== 2) begin
         n_mis++; $display("FAIL back_to_back: got p10=%h/%h p11=%h/%h pulses=%0d, required 07/1 09/2 2",
                           pad_cfg_o[10*6 +: 6], pad_mux_o[10*2 +: 2], pad_cfg_o[11*6 +: 6], pad_mux_o[11*2 +: 2], upd_cnt - u0); end
   endtask

   task automatic test_reset_mid_transfer();
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h004; PWDATA = 32'h3;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      @(posedge HCLK); #1;
      HRESETn = 1'b0;
      @(posedge HCLK); #1;
      n_cmp++; if (PREADY !== 1'b0 || pad_cfg_o !== {384{1'b1}} || pad_mux_o !== 128'h0) begin
         n_mis++; $display("FAIL mid_reset_state: got ready=%b cfg_ones=%b mux=%h, required 0/1/0",
                           PREADY, (pad_cfg_o === {384{1'b1}}), pad_mux_o); end
      PSEL = 1'b0; PENABLE = 1'b0;
      HRESETn = 1'b1;
      apb(0, 12'h004, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h0) begin
         n_mis++; $display("FAIL mid_reset_ctrl: got %h, required 0", rd); end
   endtask

   task automatic test_lock();
      apb(1, 12'h004, 32'h80000000, rd, er, lat);
      n_cmp++; if (er !== 1'b0) begin
         n_mis++; $display("FAIL lock_ctrl_write: got err=%b, required 0", er); end
      apb(1, 12'h400, 32'h00000101, rd, er, lat);
`ifdef APB_PAD_CTRL_LOCK_EN
      n_cmp++; if (er !== 1'b1 || pad_cfg_o[0 +: 6] !== 6'h3F || pad_mux_o[0 +: 2] !== 2'h0) begin
         n_mis++; $display("FAIL locked_pad_write: got err=%b pad0=%h/%h, required 1 3f/0", er, pad_cfg_o[0 +: 6], pad_mux_o[0 +: 2]); end
      apb(0, 12'h004, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h80000000) begin
         n_mis++; $display("FAIL lock_readback: got %h, required 80000000", rd); end
      apb(1, 12'h008, 32'd5, rd, er, lat);
      n_cmp++; if (er !== 1'b1) begin
         n_mis++; $display("FAIL locked_index_write: got err=%b, required 1", er); end
      do_reset();
      HRESETn = 1'b1;
      apb(0, 12'h004, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h0) begin
         n_mis++; $display("FAIL lock_cleared_by_reset: got %h, required 0", rd); end
      apb(1, 12'h400, 32'h00000101, rd, er, lat);
      n_cmp++; if (er !== 1'b0 || pad_cfg_o[0 +: 6] !== 6'h01) begin
         n_mis++; $display("FAIL unlocked_pad_write: got err=%b cfg=%h, required 0/01", er, pad_cfg_o[0 +: 6]); end
`else
      n_cmp++; if (er !== 1'b0 || pad_cfg_o[0 +: 6] !== 6'h01 || pad_mux_o[0 +: 2] !== 2'h1) begin
         n_mis++; $display("FAIL nolock_pad_write: got err=%b pad0=%h/%h, required 0 01/1", er, pad_cfg_o[0 +: 6], pad_mux_o[0 +: 2]); end
      apb(0, 12'h004, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== 32'h0) begin
         n_mis++; $display("FAIL nolock_ctrl_read: got %h, required 0", rd); end
`endif
   endtask

   initial begin
      test_reset();
      test_direct();
      test_shadow_autoinc();
      test_errors();
      test_implicit_commit();
      test_back_to_back();
      test_reset_mid_transfer();
      test_lock();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/apb_pad_ctrl_gen2.md
Name: apb_pad_ctrl_gen2

Overview:
- Parametrised APB pad-configuration block for N_IO pads.
- Holds a shadow bank and an active bank for each pad's cfg/mux fields.
- Provides an indexed data window with auto-increment, direct per-pad addressing, atomic commit and a sticky lock.
- Sits on the SoC peripheral APB and drives the pad-frame mux/cfg inputs.

Parameters:
- APB_ADDR_WIDTH, 12: APB address width; only PADDR[11:0] is decoded.
- N_IO, 64: number of pads, range 1..256.
- NBIT_PADCFG, 6: cfg bits per pad, max 8.
- NBIT_PADMUX, 2: mux bits per pad, max 8.
- IDX_W, $clog2(N_IO) (min 1): pad index width; derived localparam.

Ports:
- HCLK  in  1  sole clock.
- HRESETn  in  1  reset, synchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB direction.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  one-cycle ready pulse.
- PSLVERR  out  1  error, valid with PREADY.
- pad_cfg_o  out  N_IO x NBIT_PADCFG  active cfg bank.
- pad_mux_o  out  N_IO x NBIT_PADMUX  active mux bank.
- update_o  out  1  one-cycle pulse, cycle after the active bank changes.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values:
  - active and shadow cfg = all ones; active and shadow mux = 0
  - CTRL = 0, INDEX = 0, pending = 0, lock = 0
  - PRDATA = 0, PREADY = 0, PSLVERR = 0, update_o = 0
- APB FSM states: IDLE, ACCESS, WAIT.
  - IDLE: on PSEL&PENABLE go to ACCESS.
  - ACCESS: decode, update registers, register PRDATA/PSLVERR, set PREADY=1, go to WAIT.
  - WAIT: PREADY=0, go to IDLE.
  - Latency: PENABLE seen at cycle t gives PREADY high at t+2 for exactly one cycle.
  - PRDATA = 0 for writes.
- Register map (byte offsets):
  - 0x000 INFO RO: {N_IO[15:0], NBIT_PADMUX[7:0], NBIT_PADCFG[7:0]}.
  - 0x004 CTRL RW: bit0 SHADOW, bit1 AUTOINC, bit31 LOCK (see Optional Feature).
  - 0x008 INDEX RW: pad pointer. A write with value >= N_IO gives PSLVERR and leaves INDEX unchanged.
  - 0x00C DATA RW: window onto shadow[INDEX]; format {cfg at [8+:NBIT_PADCFG], mux at [0+:NBIT_PADMUX]}. If AUTOINC=1, any DATA access increments INDEX, wrapping N_IO-1 -> 0.
  - 0x010 COMMIT WO: writing bit0=1 copies shadow to active when SHADOW=1 and pending=1; otherwise no-op. Reads return 0.
  - 0x014 STATUS RO: bit0 pending.
  - 0x400 + 4*i: direct access to pad i, same format as DATA. i >= N_IO gives PSLVERR.
  - Any other address gives PSLVERR.
- Error responses:
  - Error reads return 0xDEADBEEF.
  - Error writes modify nothing.
- Write semantics:
  - SHADOW=0: pad writes update shadow and active in the same cycle; update_o pulses.
  - SHADOW=1: pad writes update shadow only and set pending.
  - Commit clears pending and pulses update_o.
- Reads of pad fields always return shadow, with unused bits 0.
- Leaving shadow mode (CTRL write SHADOW 1 -> 0) with pending=1 performs an implicit commit in the same cycle.
- update_o is registered: high exactly one cycle, the cycle after the active bank is written.
- Reset asserted mid-transfer aborts the transfer; the FSM returns to IDLE and all state takes its reset values.

Optional Feature:
- Macro: APB_PAD_CTRL_LOCK_EN.
- With the macro defined:
  - Writing CTRL bit31=1 sets a sticky lock, cleared only by reset.
  - While locked, writes to CTRL, INDEX, DATA, COMMIT and direct pad addresses give PSLVERR and have no effect.
  - Reads still work, and DATA reads still auto-increment INDEX.
  - CTRL bit31 reads back the lock state.
- Without the macro: bit31 reads 0, writing it is ignored, and no lock error occurs.

Decomposition:
- Package apb_pad_ctrl_pkg holds:
  - register offset constants and the direct-window base 0x400
  - CTRL bit positions
  - the APB FSM state enum {IDLE, ACCESS, WAIT}
  - the error read constant 32'hDEADBEEF
- Sub-module apb_pad_ctrl_regif holds the APB handshake FSM. It emits one-cycle access strobes (wr_stb, rd_stb, addr, wdata) and accepts the registered rdata/err.

Test Plan:
- Reset, then read 0x000 -> 0x00400206. pad_cfg_o all ones, pad_mux_o 0, PREADY high exactly once at t+2.
- SHADOW=0, write 0x400+4*5 = 0x00002A03 -> pad_cfg_o[5]=6'h2A, pad_mux_o[5]=2'h3, update_o one pulse. Read back 0x00002A03.
- SHADOW=1|AUTOINC=1, INDEX=62, DATA writes 0x101, 0x202, 0x303 -> pads 62, 63, 0 staged; INDEX=1; pending=1; outputs unchanged. COMMIT=1 -> all three applied, single update_o, pending=0.
- Error cases:
  - INDEX write 64 -> PSLVERR, INDEX unchanged.
  - Read 0x400+4*64 -> PSLVERR, 0xDEADBEEF.
  - Read 0x018 -> PSLVERR.
- SHADOW=1, stage pad 3, write CTRL=0 -> implicit commit, pad 3 active, update_o pulse.
- With APB_PAD_CTRL_LOCK_EN: write CTRL=0x80000000, then write 0x400 -> PSLVERR, pad 0 unchanged. Read CTRL -> 0x80000000. Reset clears the lock.
